boot_load_ctrl: RTL and testbench

- Sequencer that owns the single memory port shared by the multi-cycle CPU and a word-stream program loader.
- Holds the CPU in reset and streams an image into memory through a valid/ready interface.
- Then releases the CPU and counts run cycles.
- Sits between the CPU memory interface and the memory model. It muxes the port, gates CPU reset and reports status.

---
 rtl/boot_load_ctrl_pkg.sv | 15 +
 rtl/boot_load_ctrl_mem_port_mux.sv | 42 ++++
 rtl/boot_load_ctrl.sv | 131 +++++++++++++
 tb/tb_boot_load_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_load_ctrl_pkg.sv
// Shared definitions for the boot loader / CPU memory-port sequencer.
package boot_load_ctrl_pkg;

   // Sequencer states; the encoding is fixed so status decode stays stable.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      RELEASE = 2'd2,
      RUN     = 2'd3
   } state_t;

   // Each loaded word occupies four bytes of the byte-addressed memory.
   localparam int WORD_BYTES = 4;

endpackage

// File: rtl/boot_load_ctrl_mem_port_mux.sv
// Combinational owner-select of the single memory port: either the CPU
// (while it runs) or the loader (on an accepted beat); idle otherwise.
module mem_port_mux (
   input  logic        sel_cpu,
   input  logic        ld_write,
   input  logic [31:0] ld_address,
   input  logic [31:0] ld_write_data,
   input  logic [31:0] cpu_Address,
   input  logic        cpu_MemRead,
   input  logic        cpu_MemWrite,
   input  logic [31:0] cpu_Write_data,
   output logic [31:0] cpu_Read_data,
   output logic [31:0] mem_Address,
   output logic        mem_MemRead,
   output logic        mem_MemWrite,
   output logic [31:0] mem_Write_data,
   input  logic [31:0] mem_Read_data
);

   // Route address, strobes and data from whichever side owns the port.
   always_comb begin
      // NOTE: every output gets a default first so no branch can leave one
      // unassigned and infer a latch.
      mem_Address    = 32'h0;
      mem_MemRead    = 1'b0;
      mem_MemWrite   = 1'b0;
      mem_Write_data = 32'h0;
      cpu_Read_data  = 32'h0;
      if (sel_cpu) begin
         mem_Address    = cpu_Address;
         mem_MemRead    = cpu_MemRead;
         mem_MemWrite   = cpu_MemWrite;
         mem_Write_data = cpu_Write_data;
         cpu_Read_data  = mem_Read_data;
      end else if (ld_write) begin
         mem_Address    = ld_address;
         mem_MemWrite   = 1'b1;
         mem_Write_data = ld_write_data;
      end
   end

endmodule

// File: rtl/boot_load_ctrl.sv
// Boot sequencer: holds the CPU in reset while a word stream is written to
// memory, releases it after one settling cycle, then counts run cycles.
module boot_load_ctrl
   import boot_load_ctrl_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          MAX_WORDS = 256,
   parameter int          LEN_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             halt,
   input  logic [LEN_W-1:0] load_len,
   input  logic             in_valid,
   input  logic [31:0]      in_data,
   output logic             in_ready,
   output logic             cpu_rst,
   input  logic [31:0]      cpu_Address,
   input  logic             cpu_MemRead,
   input  logic             cpu_MemWrite,
   input  logic [31:0]      cpu_Write_data,
   output logic [31:0]      cpu_Read_data,
   output logic [31:0]      mem_Address,
   output logic             mem_MemRead,
   output logic             mem_MemWrite,
   output logic [31:0]      mem_Write_data,
   input  logic [31:0]      mem_Read_data,
   output logic             busy,
   output logic             running,
   output logic             error,
   output logic [31:0]      cycle_cnt
);

   state_t           state;
   logic [LEN_W-1:0] cnt;
   logic [LEN_W-1:0] len;
   logic             beat;
   logic             len_ok;
   logic             last_beat;
   logic [31:0]      ld_address;

   assign beat       = in_valid & in_ready;
   assign len_ok     = (load_len != '0) && (32'(load_len) <= 32'(MAX_WORDS));
   assign last_beat  = (cnt == len - LEN_W'(1));
   assign ld_address = BASE_ADDR + 32'(cnt) * 32'(WORD_BYTES);

   // Sequencer FSM with registered status/handshake outputs and counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         len       <= '0;
         cpu_rst   <= 1'b1;
         in_ready  <= 1'b0;
         busy      <= 1'b0;
         running   <= 1'b0;
         error     <= 1'b0;
         cycle_cnt <= 32'h0;
      end else begin
         // NOTE: non-blocking assignments so every decision below uses the
         // values registers held before this edge.
         case (state)
            IDLE: begin
               if (start) begin
                  if (len_ok) begin
                     len       <= load_len;
                     cnt       <= '0;
                     error     <= 1'b0;
                     cycle_cnt <= 32'h0;
                     in_ready  <= 1'b1;
                     busy      <= 1'b1;
                     state     <= LOAD;
                  end else begin
                     error <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (halt) begin
                  // The beat of this cycle is still written by the mux but
                  // is deliberately not counted.
                  in_ready <= 1'b0;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end else if (beat) begin
                  cnt <= cnt + LEN_W'(1);
                  if (last_beat) begin
                     in_ready <= 1'b0;
                     state    <= RELEASE;
                  end
               end
            end
            RELEASE: begin
               cpu_rst <= 1'b0;
               busy    <= 1'b0;
               running <= 1'b1;
               state   <= RUN;
            end
            RUN: begin
               if (halt) begin
                  cpu_rst <= 1'b1;
                  running <= 1'b0;
                  state   <= IDLE;
               end else if (cycle_cnt != 32'hFFFF_FFFF) begin
                  cycle_cnt <= cycle_cnt + 32'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   mem_port_mux u_mux (
      .sel_cpu        (running),
      .ld_write       (beat),
      .ld_address     (ld_address),
      .ld_write_data  (in_data),
      .cpu_Address    (cpu_Address),
      .cpu_MemRead    (cpu_MemRead),
      .cpu_MemWrite   (cpu_MemWrite),
      .cpu_Write_data (cpu_Write_data),
      .cpu_Read_data  (cpu_Read_data),
      .mem_Address    (mem_Address),
      .mem_MemRead    (mem_MemRead),
      .mem_MemWrite   (mem_MemWrite),
      .mem_Write_data (mem_Write_data),
      .mem_Read_data  (mem_Read_data)
   );

endmodule

// File: tb/tb_boot_load_ctrl.sv
// Self-checking bench for boot_load_ctrl: directed scenarios plus randomized
// loads checked against an image/cycle model held in queues and counters.
module tb_boot_load_ctrl;

   localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
   localparam int          MAX_WORDS = 256;
   localparam int          LEN_W     = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             start, halt;
   logic [LEN_W-1:0] load_len;
   logic             in_valid;
   logic [31:0]      in_data;
   logic             in_ready, cpu_rst;
   logic [31:0]      cpu_Address, cpu_Write_data, cpu_Read_data;
   logic             cpu_MemRead, cpu_MemWrite;
   logic [31:0]      mem_Address, mem_Write_data, mem_Read_data;
   logic             mem_MemRead, mem_MemWrite;
   logic             busy, running, error;
   logic [31:0]      cycle_cnt;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];

   boot_load_ctrl #(
      .BASE_ADDR (BASE_ADDR),
      .MAX_WORDS (MAX_WORDS),
      .LEN_W     (LEN_W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .halt           (halt),
      .load_len       (load_len),
      .in_valid       (in_valid),
      .in_data        (in_data),
      .in_ready       (in_ready),
      .cpu_rst        (cpu_rst),
      .cpu_Address    (cpu_Address),
      .cpu_MemRead    (cpu_MemRead),
      .cpu_MemWrite   (cpu_MemWrite),
      .cpu_Write_data (cpu_Write_data),
      .cpu_Read_data  (cpu_Read_data),
      .mem_Address    (mem_Address),
      .mem_MemRead    (mem_MemRead),
      .mem_MemWrite   (mem_MemWrite),
      .mem_Write_data (mem_Write_data),
      .mem_Read_data  (mem_Read_data),
      .busy           (busy),
      .running        (running),
      .error          (error),
      .cycle_cnt      (cycle_cnt)
   );

   always #5 clk = ~clk;

   // Record every memory write late in the cycle, well before the next edge.
   always begin
      @(negedge clk);
      #3;
      if (mem_MemWrite === 1'b1) begin
         wr_addr_q.push_back(mem_Address);
         wr_data_q.push_back(mem_Write_data);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Inputs change at the falling edge; outputs are checked 1 ns later.
   task automatic next();
      @(negedge clk);
   endtask

   task automatic clear_writes();
      wr_addr_q.delete();
      wr_data_q.delete();
   endtask

   // Valid load: start, stream len words with gaps, cross RELEASE into RUN.
   task automatic run_load(input int len, input int gmin, input int gmax,
                           input bit seq, input logic [31:0] seq_base, input bit rel_halt);
      logic [31:0] exp_d[$];
      logic [31:0] d;
      int          gap;
      clear_writes();
      next(); start = 1'b1; load_len = LEN_W'(len);
      next(); start = 1'b0; load_len = '0;
      #1;
      check("ld_in_ready", 32'(in_ready), 32'd1);
      check("ld_busy", 32'(busy), 32'd1);
      check("ld_err_clr", 32'(error), 32'd0);
      check("ld_cyc_clr", cycle_cnt, 32'd0);
      for (int i = 0; i < len; i++) begin
         gap = $urandom_range(gmax, gmin);
         for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_data  = $urandom;
            #1;
            check("gap_no_write", 32'(mem_MemWrite), 32'd0);
            next();
         end
         d = seq ? seq_base + 32'(i) : $urandom;
         exp_d.push_back(d);
         in_valid = 1'b1;
         in_data  = d;
         #1;
         check("beat_write", 32'(mem_MemWrite), 32'd1);
         check("beat_addr", mem_Address, BASE_ADDR + 32'(i * 4));
         check("beat_data", mem_Write_data, d);
         check("beat_cpu_rst", 32'(cpu_rst), 32'd1);
         next();
      end
      // RELEASE cycle: loader may keep offering words; none may be taken.
      in_valid = 1'($urandom);
      in_data  = $urandom;
      halt     = rel_halt;
      #1;
      check("rel_in_ready", 32'(in_ready), 32'd0);
      check("rel_cpu_rst", 32'(cpu_rst), 32'd1);
      check("rel_busy", 32'(busy), 32'd1);
      check("rel_running", 32'(running), 32'd0);
      check("rel_no_write", 32'(mem_MemWrite), 32'd0);
      next();
      halt     = 1'b0;
      in_valid = 1'b0;
      #1;
      check("run_cpu_rst", 32'(cpu_rst), 32'd0);
      check("run_running", 32'(running), 32'd1);
      check("run_busy", 32'(busy), 32'd0);
      check("run_cyc0", cycle_cnt, 32'd0);
      check("img_count", 32'(wr_addr_q.size()), 32'(len));
      for (int i = 0; i < len && i < wr_addr_q.size(); i++) begin
         check("img_addr", wr_addr_q[i], BASE_ADDR + 32'(i * 4));
         check("img_data", wr_data_q[i], exp_d[i]);
      end
   endtask

   // Stay in RUN for n more cycles, checking the run-cycle count each cycle.
   task automatic run_cycles(input int n);
      for (int k = 1; k <= n; k++) begin
         next();
         #1;
         check("run_cycle_cnt", cycle_cnt, 32'(k));
         check("run_stay", 32'(running), 32'd1);
      end
   endtask

   // Pulse halt in the current cycle; check the CPU is back in reset.
   task automatic do_halt(input bit with_start, input logic [31:0] held_cnt);
      halt  = 1'b1;
      start = with_start;
      load_len = LEN_W'(2);
      next();
      halt  = 1'b0;
      start = 1'b0;
      load_len = '0;
      #1;
      check("halt_cpu_rst", 32'(cpu_rst), 32'd1);
      check("halt_running", 32'(running), 32'd0);
      check("halt_busy", 32'(busy), 32'd0);
      check("halt_cyc_hold", cycle_cnt, held_cnt);
   endtask

   initial begin
      logic [31:0] d;
      int          len;
      int          nrun;
      rst = 1'b1; start = 1'b0; halt = 1'b0; load_len = '0;
      in_valid = 1'b0; in_data = 32'h0;
      cpu_Address = 32'h0; cpu_MemRead = 1'b0; cpu_MemWrite = 1'b0;
      cpu_Write_data = 32'h0; mem_Read_data = 32'h0;
      #1;
      check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_running", 32'(running), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_cycle_cnt", cycle_cnt, 32'd0);
      check("rst_mem_wr", 32'(mem_MemWrite), 32'd0);
      check("rst_mem_rd", 32'(mem_MemRead), 32'd0);
      repeat (2) next();
      rst = 1'b0;

      // Three back-to-back words, then RELEASE, then RUN.
      run_load(3, 0, 0, 1'b1, 32'hA, 1'b0);

      // RUN pass-through and cycle counting; start in RUN is ignored.
      cpu_Address = 32'h10; cpu_MemRead = 1'b1; mem_Read_data = 32'h1234;
      #1;
      check("pt_addr", mem_Address, 32'h10);
      check("pt_read", 32'(mem_MemRead), 32'd1);
      check("pt_rdata", cpu_Read_data, 32'h1234);
      check("pt_nowrite", 32'(mem_MemWrite), 32'd0);
      for (int k = 1; k <= 10; k++) begin
         next();
         start    = (k == 5);
         load_len = LEN_W'(3);
         if (k == 3) begin
            d = $urandom;
            cpu_MemWrite = 1'b1; cpu_Write_data = d; cpu_Address = 32'h44;
         end else begin
            cpu_MemWrite = 1'b0; cpu_Address = 32'h10;
         end
         #1;
         check("run_cnt", cycle_cnt, 32'(k));
         check("run_running", 32'(running), 32'd1);
         if (k == 3) begin
            check("pt_wr", 32'(mem_MemWrite), 32'd1);
            check("pt_wdata", mem_Write_data, d);
            check("pt_waddr", mem_Address, 32'h44);
         end
      end
      start = 1'b0;
      // halt together with start: halt wins.
      do_halt(1'b1, 32'd10);
      check("halt_rdata_zero", cpu_Read_data, 32'h0);
      check("halt_mem_rd", 32'(mem_MemRead), 32'd0);
      repeat (2) next();
      #1;
      check("idle_cyc_hold", cycle_cnt, 32'd10);
      check("idle_stays", 32'(busy | running), 32'd0);
      cpu_MemRead = 1'b0; cpu_Address = 32'h0;

      // Bad lengths: error set, stay IDLE, no writes.
      clear_writes();
      in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
      start = 1'b1; load_len = '0;
      next(); start = 1'b0;
      #1;
      check("err_len0", 32'(error), 32'd1);
      check("err_len0_idle", 32'(busy | in_ready), 32'd0);
      start = 1'b1; load_len = LEN_W'(MAX_WORDS + 1);
      next(); start = 1'b0; load_len = '0;
      #1;
      check("err_lenmax", 32'(error), 32'd1);
      check("err_lenmax_idle", 32'(busy | in_ready), 32'd0);
      check("err_cpu_rst", 32'(cpu_rst), 32'd1);
      check("err_cyc_hold", cycle_cnt, 32'd10);
      next();
      in_valid = 1'b0;
      check("err_no_writes", 32'(wr_addr_q.size()), 32'd0);

      // Two words with 3-cycle gaps; valid start also clears error.
      run_load(2, 3, 3, 1'b0, 32'h0, 1'b0);
      do_halt(1'b0, 32'd0);

      // Asynchronous reset after the first of four words.
      clear_writes();
      next(); start = 1'b1; load_len = LEN_W'(4);
      next(); start = 1'b0;
      in_valid = 1'b1; in_data = 32'h1111_0000;
      next();
      in_data = 32'h2222_0000;
      #1;
      check("ar_pre_write", 32'(mem_MemWrite), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      check("ar_write_off", 32'(mem_MemWrite), 32'd0);
      check("ar_in_ready", 32'(in_ready), 32'd0);
      check("ar_cpu_rst", 32'(cpu_rst), 32'd1);
      check("ar_busy", 32'(busy), 32'd0);
      repeat (2) next();
      rst = 1'b0;
      in_valid = 1'b0;
      check("ar_one_write", 32'(wr_addr_q.size()), 32'd1);
      if (wr_addr_q.size() > 0) check("ar_first_addr", wr_addr_q[0], BASE_ADDR);
      run_load(4, 0, 1, 1'b0, 32'h0, 1'b0);
      do_halt(1'b0, 32'd0);

      // halt coincident with the final beat: back to IDLE, not RELEASE.
      clear_writes();
      next(); start = 1'b1; load_len = LEN_W'(3);
      next(); start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = $urandom; halt = (i == 2);
         #1;
         check("hl_write", 32'(mem_MemWrite), 32'd1);
         next();
      end
      in_valid = 1'b0; halt = 1'b0;
      #1;
      check("hl_busy", 32'(busy), 32'd0);
      check("hl_in_ready", 32'(in_ready), 32'd0);
      check("hl_cpu_rst", 32'(cpu_rst), 32'd1);
      next();
      #1;
      check("hl_no_run", 32'(running), 32'd0);
      check("hl_cpu_rst2", 32'(cpu_rst), 32'd1);
      check("hl_writes", 32'(wr_addr_q.size()), 32'd3);

      // Randomized loads (incl. length 1 and MAX_WORDS) and run lengths.
      for (int it = 0; it < 8; it++) begin
         len = (it == 0) ? 1 : (it == 1) ? MAX_WORDS : int'($urandom_range(12, 1));
         run_load(len, 0, (it == 1) ? 0 : 3, 1'b0, 32'h0, 1'($urandom));
         nrun = $urandom_range(20, 1);
         run_cycles(nrun);
         do_halt(1'($urandom), 32'(nrun));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
